// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM responder: command encoding, mode-register
// field encodings and the burst-length decode.
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_LMR   = 3'b000,
        CMD_AREF  = 3'b001,
        CMD_PRE   = 3'b010,
        CMD_ACT   = 3'b011,
        CMD_WRITE = 3'b100,
        CMD_READ  = 3'b101,
        CMD_BST   = 3'b110,
        CMD_NOP   = 3'b111
    } cmd_e;

    localparam logic [2:0] CL_2      = 3'd2;
    localparam logic [2:0] CL_3      = 3'd3;
    localparam logic [2:0] BL_CODE_1 = 3'd0;
    localparam logic [2:0] BL_CODE_2 = 3'd1;
    localparam logic [2:0] BL_CODE_4 = 3'd2;
    localparam logic [2:0] BL_CODE_8 = 3'd3;

    // Returns the burst length in words, or 0 for an encoding we do not support.
    function automatic logic [3:0] bl_decode(input logic [2:0] code);
        case (code)
            BL_CODE_1: return 4'd1;
            BL_CODE_2: return 4'd2;
            BL_CODE_4: return 4'd4;
            BL_CODE_8: return 4'd8;
            default:   return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Byte-writable 2^MEM_AW x 16 backing store with a registered read port.
// Contents are deliberately not reset.
module sdram_resp_mem
    import sdram_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic              clk_i,
    input  logic [1:0]        be_i,
    input  logic [MEM_AW-1:0] waddr_i,
    input  logic [15:0]       wdata_i,
    input  logic [MEM_AW-1:0] raddr_i,
    output logic [15:0]       rdata_o
);
    logic [7:0]  mem_hi_q [2**MEM_AW];
    logic [7:0]  mem_lo_q [2**MEM_AW];
    logic [15:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (be_i[1]) mem_hi_q[waddr_i] <= wdata_i[15:8];
        if (be_i[0]) mem_lo_q[waddr_i] <= wdata_i[7:0];
        rdata_q <= {mem_hi_q[raddr_i], mem_lo_q[raddr_i]};
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_responder.sv
// SDRAM command-level responder: bank tracking, sequential bursts and a CAS-latency
// read pipe. Per-bank tRCD/tRP checks are built only with SDRAM_RESPONDER_TIMING_CHECK_EN.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int TRCD   = 2,
    parameter int TRP    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cke,
    input  logic        cs_n,
    input  logic        ras_n,
    input  logic        cas_n,
    input  logic        we_n,
    input  logic [1:0]  dqm,
    input  logic [12:0] a,
    input  logic [1:0]  ba,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        proto_err
);
    cmd_e              cmd;
    logic [3:0]        open_q, open_d;
    logic [12:0]       row_q [4];
    logic [12:0]       row_d [4];
    logic [2:0]        cl_q, cl_d;
    logic [3:0]        bl_q, bl_d;
    logic              err_q, err_d;
    logic              bst_act_q, bst_act_d;
    logic [2:0]        bst_cnt_q, bst_cnt_d;
    logic              bst_wr_q, bst_wr_d;
    logic              bst_ap_q, bst_ap_d;
    logic [1:0]        bst_ba_q, bst_ba_d;
    logic [12:0]       bst_row_q, bst_row_d;
    logic [8:0]        bst_col_q, bst_col_d;
    logic              beat_en, beat_wr, viol;
    logic [1:0]        beat_ba;
    logic [12:0]       beat_row;
    logic [8:0]        beat_col;
    logic [MEM_AW-1:0] beat_addr;
    logic [1:0]        mem_be, dqm_q;
    logic [15:0]       mem_rdata, rd_data2_q, dq_out_q;
    logic              rd_vld1_q, rd_vld2_q, dq_oe_q, out_vld;
    logic              act_too_soon, rw_too_soon;

    // Sequential wrap inside the BL-aligned block: start 6, BL 4 -> 6,7,4,5.
    function automatic logic [8:0] burst_col(input logic [8:0] start, input logic [2:0] beat,
                                             input logic [3:0] bl);
        logic [8:0] mask;
        mask = {5'd0, bl - 4'd1};
        return (start & ~mask) | ((start + {6'd0, beat}) & mask);
    endfunction

    assign cmd = (cke && !cs_n) ? cmd_e'({ras_n, cas_n, we_n}) : CMD_NOP;

    always_comb begin
        open_d    = open_q;
        row_d     = row_q;
        cl_d      = cl_q;
        bl_d      = bl_q;
        err_d     = err_q;
        bst_act_d = bst_act_q;
        bst_cnt_d = bst_cnt_q;
        bst_wr_d  = bst_wr_q;
        bst_ap_d  = bst_ap_q;
        bst_ba_d  = bst_ba_q;
        bst_row_d = bst_row_q;
        bst_col_d = bst_col_q;
        beat_en   = 1'b0;
        beat_wr   = 1'b0;
        beat_ba   = bst_ba_q;
        beat_row  = bst_row_q;
        beat_col  = burst_col(bst_col_q, bst_cnt_q, bl_q);
        viol      = 1'b0;

        if (bst_act_q) begin
            beat_en = 1'b1;
            beat_wr = bst_wr_q;
            if (bst_cnt_q == 3'(bl_q - 4'd1)) begin
                bst_act_d = 1'b0;
                if (bst_ap_q) open_d[bst_ba_q] = 1'b0;
            end else begin
                bst_cnt_d = bst_cnt_q + 3'd1;
            end
        end

        case (cmd)
            CMD_ACT: begin
                if (open_q[ba] || act_too_soon) begin
                    viol = 1'b1;
                end else begin
                    open_d[ba] = 1'b1;
                    row_d[ba]  = a;
                end
            end
            CMD_READ, CMD_WRITE: begin
                if (!open_q[ba] || rw_too_soon) begin
                    viol = 1'b1;
                end else begin
                    // The new command replaces any burst in flight from this cycle on.
                    beat_en   = 1'b1;
                    beat_wr   = (cmd == CMD_WRITE);
                    beat_ba   = ba;
                    beat_row  = row_q[ba];
                    beat_col  = a[8:0];
                    bst_wr_d  = (cmd == CMD_WRITE);
                    bst_ap_d  = a[10];
                    bst_ba_d  = ba;
                    bst_row_d = row_q[ba];
                    bst_col_d = a[8:0];
                    bst_cnt_d = 3'd1;
                    bst_act_d = (bl_q != 4'd1);
                    if (bl_q == 4'd1 && a[10]) open_d[ba] = 1'b0;
                end
            end
            CMD_PRE: begin
                for (int b = 0; b < 4; b++) begin
                    if (a[10] || ba == 2'(b)) open_d[b] = 1'b0;
                end
                if (bst_act_q && (a[10] || ba == bst_ba_q)) begin
                    bst_act_d = 1'b0;
                    beat_en   = 1'b0;
                end
            end
            CMD_AREF: begin
                if (|open_q) viol = 1'b1;
            end
            CMD_LMR: begin
                if ((|open_q) || !(a[6:4] == CL_2 || a[6:4] == CL_3) ||
                    bl_decode(a[2:0]) == 4'd0) begin
                    viol = 1'b1;
                end else begin
                    cl_d = a[6:4];
                    bl_d = bl_decode(a[2:0]);
                end
            end
            default: ;
        endcase

        if (viol) err_d = 1'b1;
    end

    assign beat_addr = MEM_AW'({beat_ba, beat_row, beat_col});
    assign mem_be    = (beat_en && beat_wr) ? ~dqm : 2'b00;
    assign out_vld   = (cl_q == CL_3) ? rd_vld2_q : rd_vld1_q;

    sdram_resp_mem #(
        .MEM_AW (MEM_AW)
    ) u_mem (
        .clk_i   (clk),
        .be_i    (mem_be),
        .waddr_i (beat_addr),
        .wdata_i (dq_in),
        .raddr_i (beat_addr),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q    <= '0;
            cl_q      <= CL_2;
            bl_q      <= 4'd1;
            err_q     <= 1'b0;
            bst_act_q <= 1'b0;
            bst_cnt_q <= '0;
            rd_vld1_q <= 1'b0;
            rd_vld2_q <= 1'b0;
            dqm_q     <= '0;
            dq_oe_q   <= 1'b0;
            dq_out_q  <= '0;
        end else begin
            open_q    <= open_d;
            cl_q      <= cl_d;
            bl_q      <= bl_d;
            err_q     <= err_d;
            bst_act_q <= bst_act_d;
            bst_cnt_q <= bst_cnt_d;
            rd_vld1_q <= beat_en && !beat_wr;
            rd_vld2_q <= rd_vld1_q;
            // dqm is registered once here so it lands on the word two cycles later.
            dqm_q     <= dqm;
            dq_oe_q   <= out_vld && (dqm_q != 2'b11);
            if (out_vld) dq_out_q <= (cl_q == CL_3) ? rd_data2_q : mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        row_q      <= row_d;
        bst_wr_q   <= bst_wr_d;
        bst_ap_q   <= bst_ap_d;
        bst_ba_q   <= bst_ba_d;
        bst_row_q  <= bst_row_d;
        bst_col_q  <= bst_col_d;
        rd_data2_q <= mem_rdata;
    end

`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
    logic [7:0] since_act_q [4];
    logic [7:0] since_pre_q [4];

    // Saturating per-bank distances; reset to "long ago" so the first command is legal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 4; b++) begin
                since_act_q[b] <= 8'hFF;
                since_pre_q[b] <= 8'hFF;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (!open_q[b] && open_d[b]) since_act_q[b] <= 8'd1;
                else if (since_act_q[b] != 8'hFF) since_act_q[b] <= since_act_q[b] + 8'd1;
                if (cmd == CMD_PRE && (a[10] || ba == 2'(b))) since_pre_q[b] <= 8'd1;
                else if (since_pre_q[b] != 8'hFF) since_pre_q[b] <= since_pre_q[b] + 8'd1;
            end
        end
    end

    assign rw_too_soon  = since_act_q[ba] < 8'(TRCD);
    assign act_too_soon = since_pre_q[ba] < 8'(TRP);
`else
    localparam int timing_params_unused = TRCD + TRP;
    assign rw_too_soon  = 1'b0;
    assign act_too_soon = 1'b0;
`endif

    assign dq_out    = dq_out_q;
    assign dq_oe     = dq_oe_q;
    assign proto_err = err_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: mode load, write/read bursts at CL2/CL3,
// byte masking, burst interruption, read dqm, reset mid-burst and protocol errors.
module tb_sdram_responder;

    localparam logic [2:0] C_LMR = 3'b000;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cke, cs_n, ras_n, cas_n, we_n;
    logic [1:0]  dqm;
    logic [12:0] a;
    logic [1:0]  ba;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        proto_err;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp4 [4]  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [15:0] exp_cl3 [4] = '{16'h3333, 16'h4444, 16'h1111, 16'h2222};
    logic [15:0] exp_int [11] = '{16'hA000, 16'hA001, 16'hA002, 16'hA004, 16'hA005, 16'hA006,
                                  16'hA007, 16'hA000, 16'hA001, 16'hA002, 16'hA003};

    sdram_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cke       (cke),
        .cs_n      (cs_n),
        .ras_n     (ras_n),
        .cas_n     (cas_n),
        .we_n      (we_n),
        .dqm       (dqm),
        .a         (a),
        .ba        (ba),
        .dq_in     (dq_in),
        .dq_out    (dq_out),
        .dq_oe     (dq_oe),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [12:0] addr,
                         input logic [15:0] d, input logic [1:0] m);
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = c;
        ba    = b;
        a     = addr;
        dq_in = d;
        dqm   = m;
    endtask

    task automatic idle(input logic [15:0] d, input logic [1:0] m);
        cs_n = 1'b1;
        {ras_n, cas_n, we_n} = 3'b111;
        dq_in = d;
        dqm   = m;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cke   = 1'b1;
        ba    = 2'd0;
        a     = 13'd0;
        idle(16'h0, 2'b00);
        repeat (3) tick();
        chk("reset_dq_oe", dq_oe, 16'd0);
        chk("reset_dq_out", dq_out, 16'h0000);
        chk("reset_proto_err", proto_err, 16'd0);
        rst_n = 1'b1;
        tick();

        // CL=2 BL=4 write then read on bank 1 row 5
        drive(C_LMR, 2'd0, 13'h022, 16'h0, 2'b00); tick();
        drive(C_ACT, 2'd1, 13'd5, 16'h0, 2'b00);   tick();
        idle(16'h0, 2'b00);                        tick();
        drive(C_WR, 2'd1, 13'd0, 16'h1111, 2'b00); tick();
        idle(16'h2222, 2'b00); tick();
        idle(16'h3333, 2'b00); tick();
        idle(16'h4444, 2'b00); tick();
        idle(16'h0, 2'b00);
        chk("cl2_no_err", proto_err, 16'd0);
        drive(C_RD, 2'd1, 13'd0, 16'h0, 2'b00); tick();
        idle(16'h0, 2'b00);
        chk("cl2_oe_cycle1", dq_oe, 16'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("cl2_oe", dq_oe, 16'd1);
            chk("cl2_dq", dq_out, exp4[k]);
        end
        tick();
        chk("cl2_oe_end", dq_oe, 16'd0);

        // CL=3 BL=4 read from col 2 wraps inside the block
        drive(C_PRE, 2'd0, 13'h400, 16'h0, 2'b00); tick();
        drive(C_LMR, 2'd0, 13'h032, 16'h0, 2'b00); tick();
        drive(C_ACT, 2'd1, 13'd5, 16'h0, 2'b00);   tick();
        idle(16'h0, 2'b00);                        tick();
        drive(C_RD, 2'd1, 13'd2, 16'h0, 2'b00);    tick();
        idle(16'h0, 2'b00);
        chk("cl3_oe_cycle1", dq_oe, 16'd0);
        tick();
        chk("cl3_oe_cycle2", dq_oe, 16'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("cl3_oe", dq_oe, 16'd1);
            chk("cl3_dq", dq_out, exp_cl3[k]);
        end
        tick();
        chk("cl3_oe_end", dq_oe, 16'd0);

        // BL=1 byte-masked write: upper byte kept at 00
        drive(C_PRE, 2'd0, 13'h400, 16'h0, 2'b00); tick();
        drive(C_LMR, 2'd0, 13'h020, 16'h0, 2'b00); tick();
        drive(C_ACT, 2'd1, 13'd5, 16'h0, 2'b00);   tick();
        idle(16'h0, 2'b00);                        tick();
        drive(C_WR, 2'd1, 13'd8, 16'h0000, 2'b00); tick();
        drive(C_WR, 2'd1, 13'd8, 16'hABCD, 2'b10); tick();
        drive(C_RD, 2'd1, 13'd8, 16'h0, 2'b00);    tick();
        idle(16'h0, 2'b00);                        tick();
        chk("mask_oe", dq_oe, 16'd1);
        chk("mask_dq", dq_out, 16'h00CD);
        tick();
        chk("mask_oe_end", dq_oe, 16'd0);

        // BL=8 read interrupted by a new read in its fourth cycle
        drive(C_PRE, 2'd0, 13'h400, 16'h0, 2'b00); tick();
        drive(C_LMR, 2'd0, 13'h023, 16'h0, 2'b00); tick();
        drive(C_ACT, 2'd1, 13'd5, 16'h0, 2'b00);   tick();
        idle(16'h0, 2'b00);                        tick();
        for (int k = 0; k < 8; k++) begin
            if (k == 0) drive(C_WR, 2'd1, 13'd16, 16'hA000, 2'b00);
            else        idle(16'hA000 + 16'(k), 2'b00);
            tick();
        end
        drive(C_RD, 2'd1, 13'd16, 16'h0, 2'b00); tick();
        idle(16'h0, 2'b00);
        for (int k = 0; k < 11; k++) begin
            tick();
            chk("intr_oe", dq_oe, 16'd1);
            chk("intr_dq", dq_out, exp_int[k]);
            if (k == 1) drive(C_RD, 2'd1, 13'd20, 16'h0, 2'b00);
            else        idle(16'h0, 2'b00);
        end
        tick();
        chk("intr_oe_end", dq_oe, 16'd0);

        // Read dqm blanks the word two cycles later; then reset mid-burst
        drive(C_RD, 2'd1, 13'd16, 16'h0, 2'b00); tick();
        idle(16'h0, 2'b11);                      tick();
        idle(16'h0, 2'b00);
        chk("dqm_oe_before", dq_oe, 16'd1);
        chk("dqm_dq_before", dq_out, 16'hA000);
        tick();
        chk("dqm_oe_masked", dq_oe, 16'd0);
        tick();
        chk("dqm_oe_after", dq_oe, 16'd1);
        chk("dqm_dq_after", dq_out, 16'hA002);
        rst_n = 1'b0;
        #1;
        chk("midrst_oe", dq_oe, 16'd0);
        chk("midrst_dq", dq_out, 16'h0000);
        rst_n = 1'b1;
        tick();
        chk("midrst_oe_next1", dq_oe, 16'd0);
        tick();
        chk("midrst_oe_next2", dq_oe, 16'd0);

        // After reset: banks closed, BL=1, CL=2, memory retained
        drive(C_ACT, 2'd1, 13'd5, 16'h0, 2'b00); tick();
        idle(16'h0, 2'b00);                      tick();
        drive(C_RD, 2'd1, 13'd17, 16'h0, 2'b00); tick();
        idle(16'h0, 2'b00);
        chk("postrst_oe_cycle1", dq_oe, 16'd0);
        tick();
        chk("postrst_oe", dq_oe, 16'd1);
        chk("postrst_dq", dq_out, 16'hA001);
        tick();
        chk("postrst_oe_end", dq_oe, 16'd0);
        chk("postrst_no_err", proto_err, 16'd0);

        // Read to a bank never activated
        drive(C_RD, 2'd2, 13'd0, 16'h0, 2'b00); tick();
        idle(16'h0, 2'b00);
        chk("closed_err_set", proto_err, 16'd1);
        chk("closed_oe", dq_oe, 16'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("closed_err_held", proto_err, 16'd1);
            chk("closed_oe_held", dq_oe, 16'd0);
        end

`ifdef SDRAM_RESPONDER_TIMING_CHECK_EN
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        chk("trcd_err_clear", proto_err, 16'd0);
        drive(C_ACT, 2'd0, 13'd1, 16'h0, 2'b00); tick();
        drive(C_RD, 2'd0, 13'd0, 16'h0, 2'b00);  tick();
        idle(16'h0, 2'b00);
        chk("trcd_err_set", proto_err, 16'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_responder.md
SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, meaning word-address width of the internal backing store (2^MEM_AW x 16 bits).
REQ-002 SHALL have parameter TRCD, default 2, meaning the minimum number of clocks from ACTIVE to READ/WRITE when timing checks are enabled.
REQ-003 SHALL have parameter TRP, default 2, meaning the minimum number of clocks from PRECHARGE to ACTIVE on the same bank when timing checks are enabled.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports cke, cs_n, ras_n, cas_n, we_n, all inputs of width 1, carrying the SDRAM command pins.
REQ-007 SHALL have port dqm, input, 2, byte masks; bit 1 is the upper byte and bit 0 is the lower byte.
REQ-008 SHALL have port a, input, 13, row/column/mode address; a[10] is the auto-precharge / all-banks bit.
REQ-009 SHALL have port ba, input, 2, bank select.
REQ-010 SHALL have port dq_in, input, 16, write data driven by the controller.
REQ-011 SHALL have port dq_out, output, 16, read data.
REQ-012 SHALL have port dq_oe, output, 1, high while dq_out is driven.
REQ-013 SHALL have port proto_err, output, 1, sticky protocol-violation flag.

Function
REQ-014 SHALL decode commands only when cke=1 and cs_n=0, from {ras_n,cas_n,we_n}: 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 AUTO_REFRESH, 000 LOAD_MODE, 111 NOP; all others SHALL be treated as NOP.
REQ-015 SHALL track, per bank, an open flag and a 13-bit open row; ACTIVE opens the bank; PRECHARGE closes the bank selected by ba, or all banks when a[10]=1.
REQ-016 LOAD_MODE SHALL latch CAS latency from a[6:4] (values 2 and 3 legal) and burst length from a[2:0] (0=1, 1=2, 2=4, 3=8); the reset values SHALL be CL=2 and BL=1.
REQ-017 The storage address SHALL be the low MEM_AW bits of {ba, row, col[8:0]}.
REQ-018 Bursts SHALL be sequential, with the column incrementing modulo BL inside the BL-aligned block (for example, start col 6 with BL=4 gives 6,7,4,5).
REQ-019 WRITE SHALL store dq_in in its command cycle and in the following BL-1 cycles; a byte SHALL be skipped when its same-cycle dqm bit is 1.
REQ-020 READ SHALL present the first word on dq_out with dq_oe=1 exactly CL cycles after the command cycle, and drive BL consecutive words.
REQ-021 On a read, dqm SHALL have latency 2: dqm=11 in cycle n forces dq_oe=0 in cycle n+2.
REQ-022 A new READ or WRITE SHALL truncate any burst in progress; the new command takes effect from its own cycle, and already-pipelined read words SHALL still emerge.
REQ-023 PRECHARGE of the bank in burst SHALL truncate that burst.
REQ-024 A READ or WRITE issued with a[10]=1 SHALL close the bank after the final burst beat.
REQ-025 proto_err SHALL set on: READ/WRITE to a closed bank; ACTIVE to an open bank; AUTO_REFRESH with any bank open; LOAD_MODE with any bank open or an illegal CL/BL.
REQ-026 The offending command SHALL otherwise be ignored, and proto_err SHALL stay high until reset.

Reset
REQ-027 On rst_n low, the block SHALL asynchronously set: dq_out=0, dq_oe=0, proto_err=0, all banks closed, CL=2, BL=1, burst counters and read pipeline cleared.
REQ-028 Reset mid-burst SHALL abort the burst with no further writes or read beats; memory contents are NOT cleared.

Configuration
REQ-029 With SDRAM_RESPONDER_TIMING_CHECK_EN defined, per-bank counters SHALL set proto_err on READ/WRITE fewer than TRCD cycles after ACTIVE, or ACTIVE fewer than TRP cycles after PRECHARGE.
REQ-030 Without SDRAM_RESPONDER_TIMING_CHECK_EN, no timing counters SHALL exist and TRCD/TRP SHALL be unused.

Structure
REQ-031 Package sdram_pkg SHALL hold the command enumeration, the CL/BL encodings, and the burst-length decode function.
REQ-032 Sub-module sdram_resp_mem SHALL be the byte-writable 2^MEM_AW x 16 synchronous-read array; decode, bank tracking, burst and CL pipeline stay in sdram_responder.

Verification
REQ-033 Bench SHALL cover: LOAD_MODE CL=2 BL=4; ACTIVE ba=1 row=5; WRITE col=0 data 1111,2222,3333,4444; READ col=0 -> dq_oe high 2 cycles after READ, dq_out 1111,2222,3333,4444, then dq_oe=0.
REQ-034 Bench SHALL cover: CL=3 BL=4, READ col=2 -> data from cols 2,3,0,1 starting 3 cycles after the command.
REQ-035 Bench SHALL cover: WRITE BL=1 data ABCD with dqm=10 onto a location holding 0000 -> readback 00CD.
REQ-036 Bench SHALL cover: READ to bank 2 never activated -> proto_err=1 next cycle and held; dq_oe stays 0.
REQ-037 Bench SHALL cover: BL=8 READ interrupted by READ at beat 3 -> 3 old words, then the new burst contiguously, no gap.
REQ-038 Bench SHALL cover: with SDRAM_RESPONDER_TIMING_CHECK_EN and TRCD=2, READ one cycle after ACTIVE -> proto_err=1; rst_n pulse mid-burst -> dq_oe=0 immediately.
